// File: rtl/cia_sp_tx_pkg.sv
// Shared types and constants for the CIA serial port transmitter.
//   sp_state_t   : transmitter FSM state
//   SP_DATA_W    : default bits per frame
//   SP_HALFBITS  : Timer A underflows per frame at the default width
package cia_sp_tx_pkg;

  typedef enum logic {
    SP_IDLE  = 1'b0,
    SP_SHIFT = 1'b1
  } sp_state_t;

  localparam int SP_DATA_W = 8;

  // One CNT half-period per underflow, two half-periods per bit.
  function automatic int sp_halfbits(input int data_w);
    return 2 * data_w;
  endfunction

  localparam int SP_HALFBITS = sp_halfbits(SP_DATA_W);

endpackage

// File: rtl/cia_sp_tx_if.sv
// CPU/timer side and pad side signals of the serial port transmitter.
//   master : drives phi2_dn, spmode, sdr_we, sdr_i, ta_uf; observes pads/irq/busy
//   slave  : the transmitter itself
interface cia_sp_tx_if #(
  parameter int DATA_W = 8
) ();
  logic              phi2_dn;
  logic              spmode;
  logic              sdr_we;
  logic [DATA_W-1:0] sdr_i;
  logic              ta_uf;
  logic              sp_o;
  logic              sp_oe;
  logic              cnt_o;
  logic              cnt_oe;
  logic              irq_o;
  logic              busy_o;

  modport master (
    output phi2_dn, spmode, sdr_we, sdr_i, ta_uf,
    input  sp_o, sp_oe, cnt_o, cnt_oe, irq_o, busy_o
  );

  modport slave (
    input  phi2_dn, spmode, sdr_we, sdr_i, ta_uf,
    output sp_o, sp_oe, cnt_o, cnt_oe, irq_o, busy_o
  );
endinterface

// File: rtl/cia_sp_tx.sv
// CIA serial port transmitter (SDR output mode).
// Shifts the byte written to SDR out on SP, MSB first, with CNT as bit clock.
// Each Timer A underflow is one CNT half-period; data changes on falling CNT
// and is stable at rising CNT. A holding register allows back-to-back bytes.
// Ports:
//   clk    : system clock
//   res_n  : asynchronous active-low reset
//   bus    : cia_sp_tx_if.slave (phi2_dn, spmode, sdr_we, sdr_i, ta_uf in;
//            sp_o, sp_oe, cnt_o, cnt_oe, irq_o, busy_o out, all registered)
//
// state    | meaning
// SP_IDLE  | no frame in flight, CNT high, waiting for ta_uf with a pending byte
// SP_SHIFT | frame in flight; halfbit=0 means frame done, reload on next ta_uf
module cia_sp_tx
  import cia_sp_tx_pkg::*;
#(
  parameter int DATA_W = SP_DATA_W
) (
  input  logic         clk,
  input  logic         res_n,
  cia_sp_tx_if.slave   bus
);

  localparam int HALFBITS = sp_halfbits(DATA_W);
  localparam int HB_W     = $clog2(HALFBITS) + 1;

  sp_state_t         state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [HB_W-1:0]   halfbit_q, halfbit_d;
  logic              pending_q, pending_d;
  logic              sp_q, sp_d;
  logic              cnt_q, cnt_d;
  logic              oe_q, oe_d;
  logic              irq_q, irq_d;
  logic              busy_q, busy_d;

  logic ev, wr, uf, load, step, last;

  assign ev   = bus.phi2_dn & bus.spmode;
  assign wr   = ev & bus.sdr_we;
  assign uf   = ev & bus.ta_uf;
  // halfbit_q==0 inside SP_SHIFT marks a finished frame waiting to reload
  assign load = uf & pending_q & ((state_q == SP_IDLE) || (halfbit_q == '0));
  assign step = uf & (state_q == SP_SHIFT) & (halfbit_q != '0);
  assign last = step & (halfbit_q == HB_W'(HALFBITS - 1));

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q   <= SP_IDLE;
      hold_q    <= '0;
      shift_q   <= '0;
      halfbit_q <= '0;
      pending_q <= 1'b0;
      sp_q      <= 1'b1;
      cnt_q     <= 1'b1;
      oe_q      <= 1'b0;
      irq_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      shift_q   <= shift_d;
      halfbit_q <= halfbit_d;
      pending_q <= pending_d;
      sp_q      <= sp_d;
      cnt_q     <= cnt_d;
      oe_q      <= oe_d;
      irq_q     <= irq_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!bus.spmode) begin
      state_d = SP_IDLE;
    end else if (load) begin
      state_d = SP_SHIFT;
    end else if (last && !pending_q) begin
      state_d = SP_IDLE;
    end
  end

  always_comb begin
    hold_d    = hold_q;
    shift_d   = shift_q;
    halfbit_d = halfbit_q;
    pending_d = pending_q;
    sp_d      = sp_q;
    cnt_d     = cnt_q;
    oe_d      = bus.spmode;
    irq_d     = 1'b0;
    busy_d    = busy_q;

    if (!bus.spmode) begin
      // Abort: release pads to idle levels, drop any queued byte, no irq.
      pending_d = 1'b0;
      halfbit_d = '0;
      sp_d      = 1'b1;
      cnt_d     = 1'b1;
      busy_d    = 1'b0;
    end else begin
      if (load) begin
        shift_d   = hold_q;
        sp_d      = hold_q[DATA_W-1];
        cnt_d     = 1'b0;
        halfbit_d = HB_W'(1);
        pending_d = 1'b0;
        busy_d    = 1'b1;
      end else if (step) begin
        cnt_d     = ~cnt_q;
        halfbit_d = halfbit_q + HB_W'(1);
        if (cnt_q) begin
          shift_d = shift_q << 1;
          sp_d    = shift_q[DATA_W-2];
        end
        if (last) begin
          irq_d     = 1'b1;
          halfbit_d = '0;
          if (!pending_q) begin
            busy_d = 1'b0;
          end
        end
      end
      // A same-event write lands after the load consumed the old hold value.
      if (wr) begin
        hold_d    = bus.sdr_i;
        pending_d = 1'b1;
      end
    end
  end

  assign bus.sp_o   = sp_q;
  assign bus.cnt_o  = cnt_q;
  assign bus.sp_oe  = oe_q;
  assign bus.cnt_oe = oe_q;
  assign bus.irq_o  = irq_q;
  assign bus.busy_o = busy_q;

endmodule

// File: tb/tb_cia_sp_tx.sv
// Testbench for cia_sp_tx: stimulus updates a frame-level reference model and
// pushes each byte expected to complete; a monitor rebuilds bytes from SP at
// CNT rising edges and compares on every irq pulse.
module tb_cia_sp_tx;
  import cia_sp_tx_pkg::*;

  logic clk = 1'b0;
  logic res_n = 1'b0;
  always #5 clk = ~clk;

  cia_sp_tx_if #(.DATA_W(8)) bus ();

  cia_sp_tx #(.DATA_W(8)) dut (
    .clk  (clk),
    .res_n(res_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int irq_seen = 0;

  logic [7:0] exp_q[$];

  // Reference model: frame-level view of the transmitter.
  logic [7:0] m_hold;
  logic [7:0] m_cur;
  bit         m_pending;
  bit         m_active;
  int         m_n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_hold = '0; m_cur = '0; m_pending = 0; m_active = 0; m_n = 0;
  endtask

  // One clk with the given inputs; the model applies the event rules.
  task automatic ev(input bit spm, input bit phi, input bit we, input logic [7:0] d, input bit tuf);
    bus.spmode  = spm;
    bus.phi2_dn = phi;
    bus.sdr_we  = we;
    bus.sdr_i   = d;
    bus.ta_uf   = tuf;
    if (!spm) begin
      m_active = 0; m_pending = 0; m_n = 0;
    end else if (phi) begin
      if (tuf) begin
        if (m_active && m_n < SP_HALFBITS) begin
          m_n++;
          if (m_n == SP_HALFBITS) begin
            exp_q.push_back(m_cur);
            if (!m_pending) m_active = 0;
          end
        end else if (m_pending) begin
          m_cur = m_hold; m_n = 1; m_active = 1; m_pending = 0;
        end
      end
      if (we) begin
        m_hold = d; m_pending = 1;
      end
    end
    @(posedge clk); #1;
    bus.phi2_dn = 1'b0; bus.sdr_we = 1'b0; bus.ta_uf = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    ev(1, 1, 1, d, 0);
    ev(1, 0, 0, 8'h00, 0);
  endtask

  // n underflows, each on every 4th PHI2 cycle, PHI2 every other clk.
  task automatic ufs(input int n);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 3; k++) begin
        ev(1, 1, 0, 8'h00, 0);
        ev(1, 0, 0, 8'h00, 0);
      end
      ev(1, 1, 0, 8'h00, 1);
      ev(1, 0, 0, 8'h00, 0);
    end
  endtask

  task automatic chk_idle_pins(input string tag, input bit oe);
    chk({tag, " sp_o"}, bus.sp_o, 1'b1);
    chk({tag, " cnt_o"}, bus.cnt_o, 1'b1);
    chk({tag, " sp_oe"}, bus.sp_oe, oe);
    chk({tag, " cnt_oe"}, bus.cnt_oe, oe);
    chk({tag, " irq_o"}, bus.irq_o, 1'b0);
    chk({tag, " busy_o"}, bus.busy_o, 1'b0);
  endtask

  // Monitor: rebuild bytes from SP sampled at CNT rising edges.
  logic [7:0] mon_bits = '0;
  int         mon_n = 0;
  logic       prev_cnt = 1'b1;
  logic       prev_irq = 1'b0;

  always @(negedge clk) begin
    if (!res_n || !bus.sp_oe) begin
      mon_n = 0;
      prev_irq = 1'b0;
    end else begin
      if (!prev_cnt && bus.cnt_o) begin
        mon_bits = {mon_bits[6:0], bus.sp_o};
        mon_n++;
      end
      if (bus.irq_o) begin
        irq_seen++;
        chk("irq single clk", prev_irq, 1'b0);
        if (exp_q.size() == 0) begin
          chk("unexpected irq", 1'b1, 1'b0);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          chk("byte", mon_bits, e);
          chk("cnt lows per byte", mon_n, 8);
        end
        mon_n = 0;
      end
      prev_irq = bus.irq_o;
    end
    prev_cnt = bus.cnt_o;
  end

  initial begin
    int irq0;
    bus.phi2_dn = 1'b0; bus.spmode = 1'b0; bus.sdr_we = 1'b0;
    bus.sdr_i = '0; bus.ta_uf = 1'b0;
    model_reset();
    #12;
    chk_idle_pins("reset", 1'b0);
    @(posedge clk); #1;
    res_n = 1'b1;
    ev(1, 0, 0, 8'h00, 0);

    // 0xA5, single frame, CNT returns high
    irq0 = irq_seen;
    wr(8'hA5);
    ufs(16);
    ev(1, 0, 0, 8'h00, 0);
    chk("a5 irq count", irq_seen - irq0, 1);
    chk("a5 busy end", bus.busy_o, 1'b0);
    chk("a5 cnt end", bus.cnt_o, 1'b1);
    ufs(2);
    chk("idle uf no load", bus.busy_o, 1'b0);

    // 0x3C then 0xC3 written mid-frame: no idle gap
    irq0 = irq_seen;
    wr(8'h3C);
    ufs(9);
    wr(8'hC3);
    ufs(7);
    chk("3c busy continues", bus.busy_o, 1'b1);
    ufs(16);
    chk("c3 busy end", bus.busy_o, 1'b0);
    chk("3c/c3 irq count", irq_seen - irq0, 2);

    // two writes while busy: last wins
    irq0 = irq_seen;
    wr(8'h80);
    ufs(1);
    wr(8'h11);
    ufs(3);
    wr(8'hFF);
    ufs(12);
    ufs(16);
    chk("80/ff busy end", bus.busy_o, 1'b0);
    chk("80/ff irq count", irq_seen - irq0, 2);

    // write and ta_uf on the same idle event: load deferred
    ev(1, 1, 1, 8'h6B, 1);
    chk("same-event no load", bus.busy_o, 1'b0);
    ev(1, 0, 0, 8'h00, 0);
    ufs(1);
    chk("deferred load busy", bus.busy_o, 1'b1);
    chk("deferred load msb", bus.sp_o, 1'b0);
    ufs(15);

    // abort at halfbit 7, then re-enable without a write
    irq0 = irq_seen;
    wr(8'h5A);
    ufs(7);
    ev(0, 0, 0, 8'h00, 0);
    chk_idle_pins("abort", 1'b0);
    ev(1, 0, 0, 8'h00, 0);
    ufs(3);
    chk("reenable idle busy", bus.busy_o, 1'b0);
    chk("reenable idle cnt", bus.cnt_o, 1'b1);
    chk("abort no irq", irq_seen - irq0, 0);

    // reset mid-frame
    wr(8'h77);
    ufs(5);
    #2;
    res_n = 1'b0;
    model_reset();
    #1;
    chk_idle_pins("midframe reset", 1'b0);
    @(posedge clk); #1;
    res_n = 1'b1;
    ev(1, 0, 0, 8'h00, 0);

    // randomized traffic
    for (int i = 0; i < 6000; i++) begin
      bit spm, phi, we, tuf;
      spm = ($urandom_range(0, 399) != 0);
      phi = $urandom_range(0, 1);
      we  = ($urandom_range(0, 29) == 0);
      tuf = ($urandom_range(0, 2) == 0);
      ev(spm, phi, we, 8'($urandom), tuf);
    end
    ev(1, 0, 0, 8'h00, 0);
    ufs(40);
    ev(1, 0, 0, 8'h00, 0);
    ev(1, 0, 0, 8'h00, 0);
    chk("scoreboard drained", exp_q.size(), 0);
    chk("final idle busy", bus.busy_o, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
